ultra_dist_fnd: RTL and testbench

Downstream display stage for the ultrasonic ranging block. It captures each new 9-bit distance (cm) from the ranger and converts it to three BCD digits with a sequential double-dabble engine. It drives the result onto the board's 4-digit multiplexed 7-segment display. One pending-sample buffer ensures no measurement strobe is lost while a conversion is running.

---
 rtl/ultra_fnd_pkg.sv | 60 ++++++
 rtl/ultra_dist_fnd_bcd.sv | 61 ++++++
 rtl/ultra_dist_fnd.sv | 186 ++++++++++++++++++
 tb/tb_ultra_dist_fnd.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ultra_fnd_pkg.sv
// ultra_fnd_pkg
//   Shared definitions for the ultrasonic distance display stage:
//   conversion FSM states, 7-segment font codes (active-low {dp,g,f,e,d,c,b,a}),
//   digit count, double-dabble iteration count and the BCD add-3 helper.
package ultra_fnd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fsm_state_e;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DD_ITER    = 9;

  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;
  localparam logic [7:0] FONT_DASH  = 8'hBF;

  // Segment pattern for one BCD digit; non-decimal codes show blank.
  function automatic logic [7:0] digit_font(input logic [3:0] d);
    logic [7:0] f;
    case (d)
      4'd0:    f = FONT_0;
      4'd1:    f = FONT_1;
      4'd2:    f = FONT_2;
      4'd3:    f = FONT_3;
      4'd4:    f = FONT_4;
      4'd5:    f = FONT_5;
      4'd6:    f = FONT_6;
      4'd7:    f = FONT_7;
      4'd8:    f = FONT_8;
      4'd9:    f = FONT_9;
      default: f = FONT_BLANK;
    endcase
    return f;
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
    logic [11:0] r;
    r = bcd;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ultra_dist_fnd_bcd.sv
// bcd_dd_seq
//   Sequential double-dabble converter: 9-bit binary to three BCD digits,
//   one add-3/shift iteration per clock, DD_ITER iterations per conversion.
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous reset, active-low
//   start_i     load bin_i and begin a conversion (ignored bits: none)
//   bin_i       binary value to convert, 0..511
//   done_o      high during the cycle whose clock edge performs the final
//               iteration; digits are valid from the following cycle on
//   hundreds_o  BCD hundreds digit
//   tens_o      BCD tens digit
//   ones_o      BCD ones digit
module bcd_dd_seq
  import ultra_fnd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [8:0] bin_i,
  output logic       done_o,
  output logic [3:0] hundreds_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  localparam logic [3:0] LAST_ITER = 4'(DD_ITER - 1);

  logic [8:0]  bin_q;
  logic [11:0] bcd_q;
  logic [3:0]  cnt_q;
  logic        run_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      bin_q <= bin_i;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      {bcd_q, bin_q} <= {dd_adjust(bcd_q), bin_q} << 1;
      cnt_q          <= cnt_q + 4'd1;
      if (cnt_q == LAST_ITER) begin
        run_q <= 1'b0;
      end
    end
  end

  always_comb begin
    done_o     = run_q && (cnt_q == LAST_ITER);
    hundreds_o = bcd_q[11:8];
    tens_o     = bcd_q[7:4];
    ones_o     = bcd_q[3:0];
  end

endmodule

// File: rtl/ultra_dist_fnd.sv
// ultra_dist_fnd
//   Display stage for the ultrasonic ranger. Captures each distance strobe,
//   converts it to BCD with bcd_dd_seq and scans the result onto a 4-digit
//   multiplexed common-anode 7-segment display. A one-deep pending buffer
//   (newest wins) holds a strobe that arrives while a conversion runs.
//   Build option: define ULTRA_FND_LZ_BLANK_EN to blank leading zeros on the
//   hundreds and tens digits.
// Parameters:
//   SCAN_DIV        clk cycles per digit slot, 2..2^20
//   MAX_CM          largest displayable distance; larger shows dashes
// Ports:
//   clk             system clock
//   reset           asynchronous reset, active-low
//   distance        distance in cm from the ranger
//   distance_valid  distance is new this cycle
//   fnd_com         digit enables, active-low one-hot, bit0 = ones digit
//   fnd_font        segments {dp,g,f,e,d,c,b,a}, active-low, dp always off
//   busy            conversion in progress
module ultra_dist_fnd
  import ultra_fnd_pkg::*;
#(
  parameter int SCAN_DIV = 100_000,
  parameter int MAX_CM   = 400
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8:0]            distance,
  input  logic                  distance_valid,
  output logic [NUM_DIGITS-1:0] fnd_com,
  output logic [7:0]            fnd_font,
  output logic                  busy
);

  localparam logic [19:0]           SCAN_LAST = 20'(SCAN_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] COM_ONE   = NUM_DIGITS'(1);

  fsm_state_e state_q;
  logic [8:0] pend_q;
  logic       pend_flag_q;
  logic [8:0] cap_q;
  logic [3:0] hun_q;
  logic [3:0] ten_q;
  logic [3:0] one_q;
  logic       ovr_q;
  logic       busy_q;

  logic       eng_start;
  logic [8:0] eng_bin;
  logic       eng_done;
  logic [3:0] eng_hun;
  logic [3:0] eng_ten;
  logic [3:0] eng_one;

  logic [19:0]           scan_q;
  logic [19:0]           scan_d;
  logic [1:0]            idx_q;
  logic [1:0]            idx_d;
  logic                  scan_wrap;
  logic [NUM_DIGITS-1:0] com_q;
  logic [NUM_DIGITS-1:0] com_d;
  logic [7:0]            font_q;
  logic [7:0]            font_d;
  logic                  lz_hun;
  logic                  lz_ten;

  // A queued sample takes priority over a fresh strobe in IDLE.
  always_comb begin
    eng_start = (state_q == IDLE) && (distance_valid || pend_flag_q);
    eng_bin   = pend_flag_q ? pend_q : distance;
  end

  bcd_dd_seq u_bcd (
    .clk_i      (clk),
    .rst_ni     (reset),
    .start_i    (eng_start),
    .bin_i      (eng_bin),
    .done_o     (eng_done),
    .hundreds_o (eng_hun),
    .tens_o     (eng_ten),
    .ones_o     (eng_one)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      cap_q       <= '0;
      hun_q       <= '0;
      ten_q       <= '0;
      one_q       <= '0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (eng_start) begin
            cap_q   <= eng_bin;
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            // Draining the buffer while a new strobe lands refills it
            // instead of dropping the strobe.
            if (pend_flag_q) begin
              if (distance_valid) begin
                pend_q <= distance;
              end else begin
                pend_flag_q <= 1'b0;
              end
            end
          end
        end
        SHIFT: begin
          if (eng_done) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          hun_q   <= eng_hun;
          ten_q   <= eng_ten;
          one_q   <= eng_one;
          ovr_q   <= 32'(cap_q) > MAX_CM;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (distance_valid && (state_q != IDLE)) begin
        pend_q      <= distance;
        pend_flag_q <= 1'b1;
      end
    end
  end

  always_comb begin
`ifdef ULTRA_FND_LZ_BLANK_EN
    lz_hun = (hun_q == 4'd0);
    lz_ten = lz_hun && (ten_q == 4'd0);
`else
    lz_hun = 1'b0;
    lz_ten = 1'b0;
`endif
  end

  always_comb begin
    scan_wrap = (scan_q == SCAN_LAST);
    scan_d    = scan_wrap ? '0 : scan_q + 20'd1;
    idx_d     = scan_wrap ? idx_q + 2'd1 : idx_q;
    com_d     = ~(COM_ONE << idx_q);

    font_d = FONT_BLANK;
    case (idx_q)
      2'd0:    font_d = digit_font(one_q);
      2'd1:    font_d = lz_ten ? FONT_BLANK : digit_font(ten_q);
      2'd2:    font_d = lz_hun ? FONT_BLANK : digit_font(hun_q);
      default: font_d = FONT_BLANK;
    endcase
    if (ovr_q && (idx_q != 2'd3)) begin
      font_d = FONT_DASH;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_q <= '0;
      idx_q  <= '0;
      com_q  <= '1;
      font_q <= FONT_BLANK;
    end else begin
      scan_q <= scan_d;
      idx_q  <= idx_d;
      com_q  <= com_d;
      font_q <= font_d;
    end
  end

  always_comb begin
    fnd_com  = com_q;
    fnd_font = font_q;
    busy     = busy_q;
  end

endmodule

// File: tb/tb_ultra_dist_fnd.sv
module tb_ultra_dist_fnd;

  localparam int SCAN  = 4;
  localparam int MAXCM = 400;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] distance = '0;
  logic       distance_valid = 1'b0;
  logic [3:0] fnd_com;
  logic [7:0] fnd_font;
  logic       busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ultra_dist_fnd #(
    .SCAN_DIV (SCAN),
    .MAX_CM   (MAXCM)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .distance       (distance),
    .distance_valid (distance_valid),
    .fnd_com        (fnd_com),
    .fnd_font       (fnd_font),
    .busy           (busy)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] seg(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] model_font(input int slot, input int val);
    if (slot == 3) return 8'hFF;
    if (val > MAXCM) return 8'hBF;
    if (slot == 0) return seg(val % 10);
`ifdef ULTRA_FND_LZ_BLANK_EN
    if (slot == 1 && val < 10) return 8'hFF;
    if (slot == 2 && val < 100) return 8'hFF;
`endif
    if (slot == 1) return seg((val / 10) % 10);
    return seg(val / 100);
  endfunction

  int         m_rem, m_val, m_pend, m_disp, m_edge, m_slot;
  bit         m_pend_v;
  logic [3:0] e_com  = 4'hF;
  logic [7:0] e_font = 8'hFF;
  logic       e_busy = 1'b0;

  // Conversion lasts 10 edges after acceptance; display changes on the last.
  always @(posedge clk) begin
    if (!reset) begin
      m_rem = 0; m_val = 0; m_pend = 0; m_pend_v = 0; m_disp = 0; m_edge = 0;
      e_com = 4'hF; e_font = 8'hFF; e_busy = 1'b0;
    end else begin
      m_slot = (m_edge / SCAN) % 4;
      e_com  = ~(4'b0001 << m_slot);
      e_font = model_font(m_slot, m_disp);
      m_edge++;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_disp = m_val;
        if (distance_valid) begin
          m_pend = int'(distance); m_pend_v = 1;
        end
      end else if (m_pend_v) begin
        m_val = m_pend; m_rem = 10;
        m_pend_v = distance_valid;
        if (distance_valid) m_pend = int'(distance);
      end else if (distance_valid) begin
        m_val = int'(distance); m_rem = 10;
      end
      e_busy = (m_rem > 0);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_com",  int'(fnd_com),  int'(e_com));
    chk("model_font", int'(fnd_font), int'(e_font));
    chk("model_busy", int'(busy),     int'(e_busy));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic strobe(input int v);
    tick();
    distance       = 9'(v);
    distance_valid = 1'b1;
    tick();
    distance_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("wait_idle", int'(busy), 0);
  endtask

  task automatic check_digits(input string nm, input logic [7:0] f0,
                              input logic [7:0] f1, input logic [7:0] f2,
                              input logic [7:0] f3);
    logic [7:0] exp_f [4];
    logic [3:0] want;
    int n;
    exp_f[0] = f0; exp_f[1] = f1; exp_f[2] = f2; exp_f[3] = f3;
    for (int k = 0; k < 4; k++) begin
      want = ~(4'b0001 << k);
      n = 0;
      while (fnd_com !== want && n < 64) begin
        tick();
        n++;
      end
      chk({nm, "_com"},  int'(fnd_com),  int'(want));
      chk({nm, "_font"}, int'(fnd_font), int'(exp_f[k]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int busy_cnt;

    reset = 1'b0;
    repeat (3) tick();
    chk("rst_com",  int'(fnd_com),  4'hF);
    chk("rst_font", int'(fnd_font), 8'hFF);
    chk("rst_busy", int'(busy),     0);

    reset = 1'b1;
    tick();
    chk("first_com",  int'(fnd_com),  4'hE);
    chk("first_font", int'(fnd_font), 8'hC0);

    // 123: busy length and digit fonts
    strobe(123);
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    chk("busy_len", n, 10);
    tick();
    check_digits("d123", 8'hB0, 8'hA4, 8'hF9, 8'hFF);

    strobe(400); wait_idle(); tick();
    check_digits("d400", 8'hC0, 8'hC0, 8'h99, 8'hFF);

    strobe(401); wait_idle(); tick();
    check_digits("d401", 8'hBF, 8'hBF, 8'hBF, 8'hFF);

    strobe(511); wait_idle(); tick();
    check_digits("d511", 8'hBF, 8'hBF, 8'hBF, 8'hFF);

    strobe(7); wait_idle(); tick();
`ifdef ULTRA_FND_LZ_BLANK_EN
    check_digits("d7", 8'hF8, 8'hFF, 8'hFF, 8'hFF);
`else
    check_digits("d7", 8'hF8, 8'hC0, 8'hC0, 8'hFF);
`endif

    // Pending buffer: 200 is overwritten by 301
    strobe(55);
    tick(); tick();
    strobe(200);
    tick();
    strobe(301);
    wait_idle();
    n = 0;
    while (!busy && n < 20) begin
      n++;
      tick();
    end
    chk("b2b_gap", n, 1);
    wait_idle(); tick();
    check_digits("d301", 8'hF9, 8'hC0, 8'hB0, 8'hFF);

    // Reset mid-conversion with a queued sample
    strobe(250);
    strobe(99);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("midrst_com",  int'(fnd_com),  4'hF);
    chk("midrst_font", int'(fnd_font), 8'hFF);
    chk("midrst_busy", int'(busy),     0);
    repeat (2) tick();
    reset = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy) busy_cnt++;
    end
    chk("no_restart", busy_cnt, 0);
`ifdef ULTRA_FND_LZ_BLANK_EN
    check_digits("d0", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
`else
    check_digits("d0", 8'hC0, 8'hC0, 8'hC0, 8'hFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
